// File: rtl/flash_boot_loader.sv
// Boot-time copier: reads WORD_COUNT big-endian words from byte-wide flash and
// streams them to a valid/ready memory write port. Optional macro: BOOT_CHECKSUM_EN.
module flash_boot_loader #(
  parameter int          WORD_COUNT = 32768,
  parameter int          FLASH_WAIT = 4,
  parameter logic [19:0] DEST_BASE  = 20'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [21:0] FL_ADDR,
  input  logic [7:0]  FL_DQ,
  output logic        FL_CE_N,
  output logic        FL_OE_N,
  output logic        FL_WE_N,
  output logic        FL_RST_N,
  output logic [19:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done,
  output logic [20:0] words_done,
  output logic [31:0] checksum
);

  localparam int          CW      = (FLASH_WAIT > 1) ? $clog2(FLASH_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_LD = CW'(FLASH_WAIT - 1);
  localparam logic [20:0] WC_L    = 21'(WORD_COUNT);

  typedef enum logic [1:0] {IDLE, FETCH, PUSH, DONE} state_t;

  state_t        state_q, state_d;
  logic [21:0]   fl_addr_q, fl_addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   data_q, data_d;
  logic [19:0]   maddr_q, maddr_d;
  logic [20:0]   words_q, words_d;
  logic          done_q, done_d;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0]   csum_q, csum_d;
`endif

  // Lane 0 is the lowest flash address and lands in the most significant byte.
  function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  b);
    logic [31:0] w;
    w = word;
    case (lane)
      2'd0:    w[31:24] = b;
      2'd1:    w[23:16] = b;
      2'd2:    w[15:8]  = b;
      default: w[7:0]   = b;
    endcase
    return w;
  endfunction

  always_comb begin
    state_d   = state_q;
    fl_addr_d = fl_addr_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    maddr_d   = maddr_q;
    words_d   = words_q;
    done_d    = done_q;
`ifdef BOOT_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = FETCH;
          fl_addr_d = '0;
          cnt_d     = WAIT_LD;
          words_d   = '0;
          done_d    = 1'b0;
          maddr_d   = DEST_BASE;
`ifdef BOOT_CHECKSUM_EN
          csum_d    = '0;
`endif
        end
      end
      FETCH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          // FL_ADDR[1:0] doubles as the byte index within the word.
          data_d    = insert_byte(data_q, fl_addr_q[1:0], FL_DQ);
          fl_addr_d = fl_addr_q + 22'd1;
          if (fl_addr_q[1:0] == 2'd3) state_d = PUSH;
          else                        cnt_d   = WAIT_LD;
        end
      end
      PUSH: begin
        if (mem_ready) begin
          words_d = words_q + 21'd1;
          maddr_d = maddr_q + 20'd1;
`ifdef BOOT_CHECKSUM_EN
          csum_d  = csum_q + data_q;
`endif
          if (words_q + 21'd1 == WC_L) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = FETCH;
            cnt_d   = WAIT_LD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      fl_addr_q <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      maddr_q   <= DEST_BASE;
      words_q   <= '0;
      done_q    <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      fl_addr_q <= fl_addr_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      maddr_q   <= maddr_d;
      words_q   <= words_d;
      done_q    <= done_d;
`ifdef BOOT_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign busy       = (state_q == FETCH) || (state_q == PUSH);
  assign mem_valid  = (state_q == PUSH);
  assign FL_ADDR    = fl_addr_q;
  assign FL_CE_N    = ~busy;
  assign FL_OE_N    = ~busy;
  assign FL_WE_N    = 1'b1;
  assign FL_RST_N   = 1'b1;
  assign mem_addr   = maddr_q;
  assign mem_data   = data_q;
  assign words_done = words_q;
  assign done       = done_q;
`ifdef BOOT_CHECKSUM_EN
  assign checksum   = csum_q;
`else
  assign checksum   = 32'd0;
`endif

endmodule

// File: tb/tb_flash_boot_loader.sv
// Scoreboard bench for flash_boot_loader: two instances (slow/base-0 and fast/wrapping base).
module tb_flash_boot_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start0, start1, ready0, ready1;
  logic [21:0] a0, a1;
  logic [7:0]  dq0, dq1;
  logic        ce0, oe0, we0, rs0, ce1, oe1, we1, rs1;
  logic [19:0] maddr0, maddr1;
  logic [31:0] mdata0, mdata1, cs0, cs1;
  logic        mvalid0, mvalid1, busy0, busy1, done0, done1;
  logic [20:0] wd0, wd1;

  flash_boot_loader #(.WORD_COUNT(2), .FLASH_WAIT(4), .DEST_BASE(20'h00000)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .FL_ADDR(a0), .FL_DQ(dq0),
    .FL_CE_N(ce0), .FL_OE_N(oe0), .FL_WE_N(we0), .FL_RST_N(rs0),
    .mem_addr(maddr0), .mem_data(mdata0), .mem_valid(mvalid0), .mem_ready(ready0),
    .busy(busy0), .done(done0), .words_done(wd0), .checksum(cs0));

  flash_boot_loader #(.WORD_COUNT(2), .FLASH_WAIT(1), .DEST_BASE(20'hFFFFF)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .FL_ADDR(a1), .FL_DQ(dq1),
    .FL_CE_N(ce1), .FL_OE_N(oe1), .FL_WE_N(we1), .FL_RST_N(rs1),
    .mem_addr(maddr1), .mem_data(mdata1), .mem_valid(mvalid1), .mem_ready(ready1),
    .busy(busy1), .done(done1), .words_done(wd1), .checksum(cs1));

  logic [7:0] img0 [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
  logic [7:0] img1 [8] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h02};
  always_comb dq0 = (a0 < 22'd8) ? img0[a0[2:0]] : 8'h00;
  always_comb dq1 = (a1 < 22'd8) ? img1[a1[2:0]] : 8'h00;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int st0 = 0;
  int st1 = 0;

  typedef struct {
    logic [19:0] a;
    logic [31:0] d;
    int          c;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  function automatic exp_t mk(input logic [19:0] a, input logic [31:0] d, input int c);
    exp_t e;
    e.a = a; e.d = d; e.c = c;
    return e;
  endfunction

  function automatic logic [31:0] cs_exp(input logic [31:0] sum);
`ifdef BOOT_CHECKSUM_EN
    return sum;
`else
    return 32'd0 & sum;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: handshake happens on the coming posedge; cycle is relative to the start edge.
  always begin
    @(negedge clk); #1;
    if (!reset && mvalid0 && ready0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL hs0_unexpected: got addr %0h data %0h expected no handshake", maddr0, mdata0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("hs0_addr", 32'(maddr0), 32'(e.a));
        chk("hs0_data", mdata0, e.d);
        chk("hs0_cycle", 32'(cyc + 1 - st0), 32'(e.c));
      end
    end
  end

  always begin
    @(negedge clk); #1;
    if (!reset && mvalid1 && ready1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL hs1_unexpected: got addr %0h data %0h expected no handshake", maddr1, mdata1);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("hs1_addr", 32'(maddr1), 32'(e.a));
        chk("hs1_data", mdata1, e.d);
        chk("hs1_cycle", 32'(cyc + 1 - st1), 32'(e.c));
      end
    end
  end

  task automatic start_pulse(input int which);
    @(negedge clk);
    if (which == 0) begin start0 = 1'b1; st0 = cyc + 1; end
    else            begin start1 = 1'b1; st1 = cyc + 1; end
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_rel0(input int r);
    while (cyc - st0 < r) @(negedge clk);
  endtask

  task automatic wait_done(input int which, input int budget);
    int n = 0;
    while (((which == 0) ? !done0 : !done1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_within_budget", 32'((which == 0) ? done0 : done1), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; ready0 = 1'b1; ready1 = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_fl_addr", 32'(a0), 32'd0);
    chk("rst_mem_addr", 32'(maddr0), 32'd0);
    chk("rst_mem_data", mdata0, 32'd0);
    chk("rst_words", 32'(wd0), 32'd0);
    chk("rst_checksum", cs0, 32'd0);
    chk("rst_valid", 32'(mvalid0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_ce_n", 32'(ce0), 32'd1);
    chk("rst_oe_n", 32'(oe0), 32'd1);
    chk("rst_we_n", 32'(we0), 32'd1);
    chk("rst_rst_n", 32'(rs0), 32'd1);
    chk("rst_mem_addr1", 32'(maddr1), 32'hFFFFF);
    reset = 1'b0;

    // Basic copy
    q0.push_back(mk(20'h0, 32'h12345678, 17));
    q0.push_back(mk(20'h1, 32'hDEADBEEF, 34));
    start_pulse(0);
    wait_rel0(1);
    chk("basic_busy", 32'(busy0), 32'd1);
    chk("basic_ce_n", 32'(ce0), 32'd0);
    chk("basic_oe_n", 32'(oe0), 32'd0);
    wait_rel0(35);
    chk("basic_done", 32'(done0), 32'd1);
    chk("basic_busy_end", 32'(busy0), 32'd0);
    chk("basic_words", 32'(wd0), 32'd2);
    chk("basic_ce_n_end", 32'(ce0), 32'd1);
    chk("basic_mem_addr", 32'(maddr0), 32'd2);
    chk("basic_fl_addr", 32'(a0), 32'd8);
    chk("basic_checksum", cs0, cs_exp(32'hF0E21567));
    chk("basic_queue_empty", 32'(q0.size()), 32'd0);

    // Backpressure: 10 stalled cycles in the first PUSH
    ready0 = 1'b0;
    q0.push_back(mk(20'h0, 32'h12345678, 27));
    q0.push_back(mk(20'h1, 32'hDEADBEEF, 44));
    start_pulse(0);
    chk("bp_done_cleared", 32'(done0), 32'd0);
    begin
      int n = 0;
      while (!mvalid0 && n < 40) begin @(negedge clk); n++; end
    end
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(mvalid0), 32'd1);
      chk("bp_data", mdata0, 32'h12345678);
      chk("bp_fl_addr", 32'(a0), 32'd4);
      @(negedge clk);
    end
    ready0 = 1'b1;
    wait_done(0, 60);
    chk("bp_words", 32'(wd0), 32'd2);
    chk("bp_queue_empty", 32'(q0.size()), 32'd0);

    // Reset during byte 2 of word 1
    q0.push_back(mk(20'h0, 32'h12345678, 17));
    start_pulse(0);
    wait_rel0(26);
    chk("mid_fl_addr", 32'(a0), 32'd6);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_valid", 32'(mvalid0), 32'd0);
    chk("mid_busy", 32'(busy0), 32'd0);
    chk("mid_words", 32'(wd0), 32'd0);
    chk("mid_ce_n", 32'(ce0), 32'd1);
    chk("mid_fl_addr_rst", 32'(a0), 32'd0);
    chk("mid_done", 32'(done0), 32'd0);
    chk("mid_checksum", cs0, 32'd0);
    reset = 1'b0;
    q0.push_back(mk(20'h0, 32'h12345678, 17));
    q0.push_back(mk(20'h1, 32'hDEADBEEF, 34));
    start_pulse(0);
    wait_done(0, 60);
    chk("mid_recopy_words", 32'(wd0), 32'd2);
    chk("mid_recopy_checksum", cs0, cs_exp(32'hF0E21567));

    // Start while busy is ignored
    q0.push_back(mk(20'h0, 32'h12345678, 17));
    q0.push_back(mk(20'h1, 32'hDEADBEEF, 34));
    start_pulse(0);
    for (int r = 1; r <= 16; r++) begin
      wait_rel0(r);
      chk("busy_fl_addr_seq", 32'(a0), 32'(r / 4));
      if (r == 4) start0 = 1'b1;
      if (r == 5) start0 = 1'b0;
    end
    wait_done(0, 60);
    chk("busy_words", 32'(wd0), 32'd2);
    q0.push_back(mk(20'h0, 32'h12345678, 17));
    q0.push_back(mk(20'h1, 32'hDEADBEEF, 34));
    start_pulse(0);
    chk("again_done_cleared", 32'(done0), 32'd0);
    chk("again_busy", 32'(busy0), 32'd1);
    wait_done(0, 60);
    chk("again_words", 32'(wd0), 32'd2);
    chk("again_queue_empty", 32'(q0.size()), 32'd0);

    // FLASH_WAIT=1, wrapping destination, checksum wrap
    q1.push_back(mk(20'hFFFFF, 32'hFFFFFFFF, 5));
    q1.push_back(mk(20'h00000, 32'h00000002, 10));
    start_pulse(1);
    wait_done(1, 30);
    chk("fast_words", 32'(wd1), 32'd2);
    chk("fast_mem_addr", 32'(maddr1), 32'd1);
    chk("fast_checksum", cs1, cs_exp(32'h00000001));
    chk("fast_busy", 32'(busy1), 32'd0);
    chk("fast_ce_oe", 32'({ce1, oe1}), 32'd3);
    chk("fast_we_rst", 32'({we1, rs1}), 32'd3);
    chk("fast_data_last", mdata1, 32'h00000002);
    chk("fast_queue_empty", 32'(q1.size()), 32'd0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flash_boot_loader.md
Name: flash_boot_loader

Overview:
- Boot-time copier between the board flash (byte-wide, 22-bit byte address) and the CPU's main memory write port.
- Reads WORD_COUNT consecutive 32-bit words from flash, one byte at a time with a programmable access wait.
- Assembles each word big-endian: the byte at address offset 0 becomes bits [31:24].
- Presents each assembled word on a valid/ready write port; the CPU is held in reset until done.

Parameters:
- WORD_COUNT, 32768, number of 32-bit words to copy (1..1048576).
- FLASH_WAIT, 4, cycles FL_ADDR is held stable before FL_DQ is sampled (>=1).
- DEST_BASE, 0, word address of the first destination word (20 bits).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a copy.
- FL_ADDR  out  22  flash byte address.
- FL_DQ  in  8  flash read data.
- FL_CE_N  out  1  flash chip enable; low while busy.
- FL_OE_N  out  1  flash output enable; low while busy.
- FL_WE_N  out  1  constant 1 (no flash writes).
- FL_RST_N  out  1  constant 1.
- mem_addr  out  20  destination word address.
- mem_data  out  32  assembled word.
- mem_valid  out  1  word available.
- mem_ready  in  1  sink accepts the word this cycle.
- busy  out  1  copy in progress.
- done  out  1  copy complete; sticky.
- words_done  out  21  count of words accepted.
- checksum  out  32  see Optional Feature.

Behaviour:
- Reset values:
  - FL_ADDR=0, mem_addr=DEST_BASE, mem_data=0, words_done=0, checksum=0.
  - mem_valid=0, busy=0, done=0, FL_CE_N=1, FL_OE_N=1.
  - The FSM goes to IDLE.
- Reset mid-operation aborts immediately. Any partial word is discarded, and no mem_valid is asserted in the cycle after reset.
- States:
  - IDLE -> FETCH on start=1.
    - On entry, FL_ADDR=0, byte index=0, wait counter=FLASH_WAIT-1, words_done=0, done=0, and busy=1 from the next cycle.
  - FETCH: FL_ADDR is held and the counter decrements each cycle.
    - When the counter hits 0, FL_DQ is registered into the byte lane given by the index: lane 0=[31:24], 1=[23:16], 2=[15:8], 3=[7:0].
    - If the index is below 3: increment FL_ADDR and the index, reload the counter, and stay in FETCH.
    - If the index is 3: go to PUSH with mem_valid=1 next cycle. FL_ADDR advances to the next word's byte 0 in the same edge.
  - PUSH: mem_valid=1; mem_data and mem_addr are stable until mem_ready=1.
    - On the handshake edge: words_done+1, mem_addr+1, mem_valid=0.
    - If words_done+1==WORD_COUNT, go to DONE; otherwise go to FETCH with a reloaded counter.
  - DONE: done=1, busy=0, FL_CE_N=FL_OE_N=1.
    - start re-enters FETCH as from IDLE and clears done.
- Handshake rules:
  - start is ignored while busy.
  - There is no flash prefetch during PUSH, so mem_ready backpressure stalls flash reads.
- Timing: each byte takes FLASH_WAIT cycles, and PUSH is at least 1 cycle.
  - With mem_ready held at 1, one word takes 4*FLASH_WAIT+1 cycles.
  - The first mem_valid rises 4*FLASH_WAIT+1 cycles after the start edge (17 cycles for the defaults).
- Widths and wrap:
  - FL_ADDR = 4*word_index + byte_index, truncated to 22 bits.
  - mem_addr wraps modulo 2^20.
  - words_done is 21 bits, so it holds WORD_COUNT=2^20 without overflow.
- FL_ADDR[1:0] always equals the current byte index.

Optional Feature:
- Macro: BOOT_CHECKSUM_EN.
- Defined: checksum accumulates the modulo-2^32 sum of every word on its handshake edge. It is cleared on reset and on an accepted start, and it holds its value in DONE.
- Undefined: checksum is constant 0 and no adder is synthesized.

Test Plan:
- Basic copy: WORD_COUNT=2, FLASH_WAIT=4, flash words 0x12345678 and 0xDEADBEEF, mem_ready=1.
  - Handshakes: (addr 0, 0x12345678) at cycle 17, then (addr 1, 0xDEADBEEF) at cycle 34.
  - done=1 at cycle 35; words_done=2.
- Backpressure: hold mem_ready=0 for 10 cycles in the first PUSH.
  - mem_valid stays 1, mem_data stays 0x12345678, and FL_ADDR stays 4.
  - The second word's handshake slips by 10 cycles.
- Reset mid-copy: assert reset during byte 2 of word 1.
  - Next cycle: mem_valid=0, busy=0, words_done=0, FL_CE_N=1.
  - A fresh start copies from FL_ADDR 0 correctly.
- Start while busy: pulse start at cycle 5.
  - No restart; FL_ADDR sequence is 0, 1, 2, 3, 4 unchanged.
  - A start after done re-copies and clears done.
- Edge parameters: FLASH_WAIT=1 with mem_ready=1 gives one word every 5 cycles. DEST_BASE=0xFFFFF makes the second word's mem_addr wrap to 0.
- Checksum: with BOOT_CHECKSUM_EN, words 0xFFFFFFFF and 0x00000002 give checksum=0x00000001. Without the macro, checksum=0.
